dataflow_router: RTL and testbench
==================================

// Module: dataflow_router
// PURPOSE
//  Parametrised, elastic successor to the dataflow lane-distribution stage.
//  - Takes one LANE x TILE tile of fixed-point words per transfer.
//  - Routes it to the PE-array lanes in one of four modes: broadcast, pass, rotate, zero.
//  - Uses valid/ready on both sides, a 2-stage pipeline, and full 1-tile/cycle throughput.
//  - Sits between the buffer read ports and the MAC-lane array.
// PARAMETERS
//  IL      4    integer bits per word
//  FL      16   fraction bits per word; word width W = IL+FL
//  LANE    128  lane count; must be a power of two >= 2
//  TILE    16   words per lane
//  SRC_W   $clog2(LANE)  width of src_lane (derived, do not override)
// PORTS
//  clk        in   1                   clock, rising edge
//  reset      in   1                   asynchronous, active-low reset
//  flush      in   1                   synchronous pipeline clear, active-high
//  in_valid   in   1                   input tile valid
//  in_ready   out  1                   router can accept a tile
//  mode       in   2                   0 BCAST, 1 PASS, 2 ROT, 3 ZERO; sampled with tile
//  src_lane   in   SRC_W               BCAST source lane / ROT offset; sampled with tile
//  in         in   signed W [LANE][TILE]  input tile
//  out_valid  out  1                   output tile valid
//  out_ready  in   1                   downstream accepts the tile
//  out        out  signed W [LANE][TILE]  routed tile
//  xfer_count out  32                  only with DATAFLOW_PERF_EN
//  stall_count out 32                  only with DATAFLOW_PERF_EN
// BEHAVIOUR
//  Reset (reset==0, async):
//  - s1_valid, out_valid, all data registers and counters clear to 0.
//  - in_ready reads 1 on the first edge after release.
//  Stage s1 (capture):
//  - Loads in, mode and src_lane when in_valid && in_ready.
//  - in_ready = !flush && (!s1_valid || !out_valid || out_ready), combinational.
//  Stage s2 (route and output):
//  - Loads the routed s1 data when s1_valid && (!out_valid || out_ready).
//  - Otherwise holds.
//  - out_valid clears when out_ready is high and no new tile arrives.
//  - Latency 2 cycles from the input handshake to out_valid.
//  - Back-to-back input with out_ready held high gives one tile per cycle.
//  Routing, per lane i and word k:
//  - BCAST: out[i][k] = in[src_lane][k]
//  - PASS:  out[i][k] = in[i][k]
//  - ROT:   out[i][k] = in[(i+src_lane) mod LANE][k]; wraps naturally via SRC_W bits
//  - ZERO:  out[i][k] = 0; still a valid transfer (drains the lanes)
//  - No arithmetic on words; bit-exact copy of the signed W-bit value.
//  Stall:
//  - While out_valid && !out_ready, out and out_valid are held stable.
//  - s1 may still fill once; in_ready then drops.
//  Mode changes:
//  - mode and src_lane are taken per tile; changing them between tiles never corrupts an in-flight tile.
//  flush (synchronous, wins over everything):
//  - Next edge: s1_valid = out_valid = 0.
//  - in_ready is 0 during flush; a tile offered in that cycle is not accepted.
//  - Data registers keep stale values (don't care while invalid).
//  Reset mid-transfer:
//  - The tile is dropped, with no partial output.
//  - Asserting reset overrides flush and handshakes.
// CONFIGURATION
//  DATAFLOW_PERF_EN defined:
//  - xfer_count increments on each out_valid && out_ready.
//  - stall_count increments on each out_valid && !out_ready.
//  - Both saturate at 32'hFFFF_FFFF; both clear on reset or flush.
//  DATAFLOW_PERF_EN undefined:
//  - Counter ports and logic are absent; routing and timing are identical.
// TESTING
//  1 Reset then PASS: in[i][k]=i*16+k, out_ready=1 -> out_valid 2 cycles later, out==in, in_ready=1 throughout.
//  2 BCAST src_lane=5: in[5][k]=k+1, other lanes 0 -> every out[i][k]==k+1.
//  3 ROT src_lane=LANE-1 -> out[0]=in[LANE-1], out[1]=in[0]; wrap verified.
//  4 Four back-to-back tiles, out_ready low for 3 cycles -> out held stable; in_ready drops after s1 fills;
//    all 4 tiles delivered in order, none lost or duplicated; with PERF, xfer=4 and stall=3.
//  5 flush with s1 and s2 both valid and in_valid=1 -> next cycle out_valid=0, offered tile not accepted;
//    with PERF, counters read 0.
//  6 reset low mid-stream (async, between edges) -> out_valid and in_ready-blocking state clear
//    immediately; after release a ZERO-mode tile yields all-zero out with out_valid=1.

Source files
------------

// File: rtl/dataflow_router.sv
// Elastic two-stage router: one LANE x TILE tile per transfer, spread across lanes as BCAST/PASS/ROT/ZERO.
// Optional build macro DATAFLOW_PERF_EN adds saturating xfer_count / stall_count outputs.
`timescale 1ns/1ps
module dataflow_router #(
  parameter int IL    = 4,
  parameter int FL    = 16,
  parameter int LANE  = 128,
  parameter int TILE  = 16,
  // Derived from LANE; leave at default.
  parameter int SRC_W = $clog2(LANE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              mode,
  input  logic [SRC_W-1:0]        src_lane,
  input  logic signed [IL+FL-1:0] in  [LANE][TILE],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [IL+FL-1:0] out [LANE][TILE]
`ifdef DATAFLOW_PERF_EN
  ,
  output logic [31:0]             xfer_count,
  output logic [31:0]             stall_count
`endif
);

  localparam int W = IL + FL;

  typedef enum logic [1:0] {
    MODE_BCAST = 2'd0,
    MODE_PASS  = 2'd1,
    MODE_ROT   = 2'd2,
    MODE_ZERO  = 2'd3
  } mode_e;

  typedef logic signed [W-1:0] tile_t [LANE][TILE];

  logic             s1_valid_q, s1_valid_d;
  mode_e            s1_mode_q, s1_mode_d;
  logic [SRC_W-1:0] s1_src_q, s1_src_d;
  tile_t            s1_data_q, s1_data_d;
  logic             out_valid_q, out_valid_d;
  tile_t            out_q, out_d;
  tile_t            routed;
  logic [SRC_W-1:0] rot_idx [LANE];
  logic             in_fire, s2_load;

  // s1 is free when it is empty or when its tile moves into s2 this cycle.
  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !flush && (!s1_valid_q || !out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;

  // Rotation offset wraps modulo LANE through the SRC_W-bit truncation.
  always_comb begin
    for (int i = 0; i < LANE; i++) begin
      rot_idx[i] = SRC_W'(i) + s1_src_q;
    end
  end

  always_comb begin
    for (int i = 0; i < LANE; i++) begin
      for (int k = 0; k < TILE; k++) begin
        case (s1_mode_q)
          MODE_BCAST: routed[i][k] = s1_data_q[s1_src_q][k];
          MODE_PASS:  routed[i][k] = s1_data_q[i][k];
          MODE_ROT:   routed[i][k] = s1_data_q[rot_idx[i]][k];
          default:    routed[i][k] = '0;
        endcase
      end
    end
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block leaves a latch.
    s1_valid_d  = s1_valid_q;
    s1_mode_d   = s1_mode_q;
    s1_src_d    = s1_src_q;
    s1_data_d   = s1_data_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;

    if (in_fire) begin
      s1_data_d = in;
      s1_mode_d = mode_e'(mode);
      s1_src_d  = src_lane;
    end
    if (s2_load) begin
      out_d = routed;
    end

    // Flush only clears the valid bits; data left behind is ignored while invalid.
    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (in_fire)      s1_valid_d = 1'b1;
      else if (s2_load) s1_valid_d = 1'b0;

      if (s2_load)        out_valid_d = 1'b1;
      else if (out_ready) out_valid_d = 1'b0;
    end
  end

  // NOTE: the tile registers are cleared on reset too, so out reads all-zero straight after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: state registers take <= so every flop samples pre-edge values.
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= MODE_BCAST;
      s1_src_q    <= '0;
      s1_data_q   <= '{default: '0};
      out_valid_q <= 1'b0;
      out_q       <= '{default: '0};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_src_q    <= s1_src_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;

`ifdef DATAFLOW_PERF_EN
  logic [31:0] xfer_count_q, xfer_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    xfer_count_d  = xfer_count_q;
    stall_count_d = stall_count_q;
    if (flush) begin
      xfer_count_d  = '0;
      stall_count_d = '0;
    end else begin
      if (out_valid_q && out_ready && (xfer_count_q != '1))
        xfer_count_d = xfer_count_q + 32'd1;
      if (out_valid_q && !out_ready && (stall_count_q != '1))
        stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xfer_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      xfer_count_q  <= xfer_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign xfer_count  = xfer_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_dataflow_router.sv
// Self-checking bench for dataflow_router: random tiles against a lane-routing reference model.
// Counter checks are compiled in when DATAFLOW_PERF_EN is defined.
`timescale 1ns/1ps
module tb_dataflow_router;

  localparam int IL    = 4;
  localparam int FL    = 16;
  localparam int LANE  = 128;
  localparam int TILE  = 16;
  localparam int W     = IL + FL;
  localparam int SRC_W = $clog2(LANE);

  typedef logic signed [W-1:0] tile_t [LANE][TILE];

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [SRC_W-1:0] src_lane;
  tile_t            in_tile;
  logic             out_valid;
  logic             out_ready;
  tile_t            out_tile;
`ifdef DATAFLOW_PERF_EN
  logic [31:0]      xfer_count;
  logic [31:0]      stall_count;
`endif

  int    errors = 0;
  int    checks = 0;
  tile_t exp_t;
  tile_t exp_mem [16];

  always #5 clk = ~clk;

  dataflow_router #(.IL(IL), .FL(FL), .LANE(LANE), .TILE(TILE)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mode       (mode),
    .src_lane   (src_lane),
    .in         (in_tile),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out_tile)
`ifdef DATAFLOW_PERF_EN
    ,
    .xfer_count (xfer_count),
    .stall_count(stall_count)
`endif
  );

  // Reference routing straight from the lane rules, using integer modulo for the rotation.
  task automatic model_route(input tile_t src_t, input logic [1:0] m, input int s, output tile_t r);
    for (int i = 0; i < LANE; i++) begin
      for (int k = 0; k < TILE; k++) begin
        case (m)
          2'd0:    r[i][k] = src_t[s][k];
          2'd1:    r[i][k] = src_t[i][k];
          2'd2:    r[i][k] = src_t[(i + s) % LANE][k];
          default: r[i][k] = '0;
        endcase
      end
    end
  endtask

  function automatic int tile_diff(input tile_t a, input tile_t b);
    int n = 0;
    for (int i = 0; i < LANE; i++)
      for (int k = 0; k < TILE; k++)
        if (a[i][k] !== b[i][k]) n++;
    return n;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < LANE; i++)
      for (int k = 0; k < TILE; k++)
        in_tile[i][k] = W'($urandom());
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tile_t zero_t;
    int d;
    for (int i = 0; i < LANE; i++)
      for (int k = 0; k < TILE; k++)
        zero_t[i][k] = '0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mode = 2'd0; src_lane = '0;
    fill_random();
    step(); step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    d = tile_diff(out_tile, zero_t);
    checks++;
    if (d != 0) begin errors++; $display("FAIL reset_out_data: %0d nonzero words, want 0", d); end
`ifdef DATAFLOW_PERF_EN
    checks++;
    if (xfer_count !== 32'd0 || stall_count !== 32'd0) begin
      errors++; $display("FAIL reset_counters: xfer=%0d stall=%0d want 0/0", xfer_count, stall_count);
    end
`endif
    #3 rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_pass();
    int d;
    for (int i = 0; i < LANE; i++)
      for (int k = 0; k < TILE; k++)
        in_tile[i][k] = W'(i * 16 + k);
    mode = 2'd1; src_lane = SRC_W'($urandom()); in_valid = 1'b1; out_ready = 1'b1;
    model_route(in_tile, mode, int'(src_lane), exp_t);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL pass_ready_c0: got %b want 1", in_ready); end
    step();
    // New input after the handshake must not leak into the in-flight tile.
    in_valid = 1'b0; mode = 2'd3; fill_random();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL pass_c1: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    step(); #1;
    d = tile_diff(out_tile, exp_t);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL pass_c2: out_valid=%b in_ready=%b want 1/1", out_valid, in_ready);
    end
    checks++;
    if (d != 0) begin errors++; $display("FAIL pass_data: %0d words differ, want 0", d); end
    step(); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_drain: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_bcast();
    int d;
    for (int i = 0; i < LANE; i++)
      for (int k = 0; k < TILE; k++)
        in_tile[i][k] = (i == 5) ? W'(k + 1) : '0;
    mode = 2'd0; src_lane = SRC_W'(5); in_valid = 1'b1; out_ready = 1'b1;
    model_route(in_tile, 2'd0, 5, exp_t);
    step(); in_valid = 1'b0;
    step(); #1;
    d = tile_diff(out_tile, exp_t);
    checks++;
    if (out_valid !== 1'b1 || d != 0) begin
      errors++; $display("FAIL bcast: out_valid=%b diff_words=%0d want 1/0", out_valid, d);
    end
    step();
  endtask

  task automatic test_rot();
    tile_t rot_in;
    int d, n;
    fill_random();
    rot_in = in_tile;
    mode = 2'd2; src_lane = SRC_W'(LANE - 1); in_valid = 1'b1; out_ready = 1'b1;
    model_route(in_tile, 2'd2, LANE - 1, exp_t);
    step(); in_valid = 1'b0;
    step(); #1;
    d = tile_diff(out_tile, exp_t);
    checks++;
    if (out_valid !== 1'b1 || d != 0) begin
      errors++; $display("FAIL rot: out_valid=%b diff_words=%0d want 1/0", out_valid, d);
    end
    n = 0;
    for (int k = 0; k < TILE; k++) begin
      if (out_tile[0][k] !== rot_in[LANE-1][k]) n++;
      if (out_tile[1][k] !== rot_in[0][k]) n++;
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL rot_wrap: %0d wrapped words differ, want 0", n); end
    step();
  endtask

  task automatic test_back_to_back();
    tile_t snap;
    bit held_v = 0, saw_block = 0, exp_rdy;
    int sent = 0, got = 0, occ = 0, stalls = 0, d;
    flush = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    flush = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      if (sent < 4) begin
        fill_random(); mode = 2'($urandom_range(0, 3)); src_lane = SRC_W'($urandom()); in_valid = 1'b1;
      end else in_valid = 1'b0;
      out_ready = !(cyc >= 3 && cyc < 6);
      #1;
      exp_rdy = (occ < 2) || out_ready;
      checks++;
      if (in_ready !== exp_rdy) begin errors++; $display("FAIL b2b_ready c%0d: got %b want %b", cyc, in_ready, exp_rdy); end
      if (in_valid && !in_ready) saw_block = 1;
      if (held_v) begin
        d = tile_diff(out_tile, snap);
        checks++;
        if (out_valid !== 1'b1 || d != 0) begin
          errors++; $display("FAIL b2b_hold c%0d: out_valid=%b changed_words=%0d want 1/0", cyc, out_valid, d);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (got >= sent) begin
          errors++; $display("FAIL b2b_extra c%0d: delivery %0d with only %0d sent", cyc, got, sent);
        end else begin
          d = tile_diff(out_tile, exp_mem[got]);
          if (d != 0) begin errors++; $display("FAIL b2b_data tile%0d: %0d words differ, want 0", got, d); end
        end
        got++; occ--;
      end
      if (out_valid && !out_ready) stalls++;
      if (in_valid && in_ready) begin
        model_route(in_tile, mode, int'(src_lane), exp_mem[sent]);
        sent++; occ++;
      end
      held_v = out_valid && !out_ready;
      snap = out_tile;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (got != 4) begin errors++; $display("FAIL b2b_count: delivered %0d want 4", got); end
    checks++;
    if (!saw_block) begin errors++; $display("FAIL b2b_backpressure: in_ready never dropped, want a drop"); end
`ifdef DATAFLOW_PERF_EN
    checks++;
    if (xfer_count !== 32'd4 || stall_count !== 32'(stalls)) begin
      errors++; $display("FAIL b2b_perf: xfer=%0d stall=%0d want 4/%0d", xfer_count, stall_count, stalls);
    end
`endif
  endtask

  task automatic test_random_stream();
    localparam int N = 12;
    bit exp_rdy;
    int sent = 0, got = 0, occ = 0, stalls = 0, d, bad = 0;
    flush = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    flush = 1'b0;
    for (int cyc = 0; cyc < 300 && got < N; cyc++) begin
      if (sent < N && ($urandom_range(0, 9) < 7)) begin
        fill_random(); mode = 2'($urandom_range(0, 3)); src_lane = SRC_W'($urandom()); in_valid = 1'b1;
      end else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      exp_rdy = (occ < 2) || out_ready;
      if (in_ready !== exp_rdy) bad++;
      if (out_valid && out_ready) begin
        checks++;
        if (got >= sent) begin
          errors++; $display("FAIL rand_extra c%0d: delivery %0d with only %0d sent", cyc, got, sent);
        end else begin
          d = tile_diff(out_tile, exp_mem[got]);
          if (d != 0) begin errors++; $display("FAIL rand_data tile%0d: %0d words differ, want 0", got, d); end
        end
        got++; occ--;
      end
      if (out_valid && !out_ready) stalls++;
      if (in_valid && in_ready) begin
        model_route(in_tile, mode, int'(src_lane), exp_mem[sent]);
        sent++; occ++;
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rand_ready: %0d cycles with wrong in_ready, want 0", bad); end
    checks++;
    if (got != N) begin errors++; $display("FAIL rand_count: delivered %0d want %0d", got, N); end
`ifdef DATAFLOW_PERF_EN
    checks++;
    if (xfer_count !== 32'(N) || stall_count !== 32'(stalls)) begin
      errors++; $display("FAIL rand_perf: xfer=%0d stall=%0d want %0d/%0d", xfer_count, stall_count, N, stalls);
    end
`endif
  endtask

  task automatic test_flush();
    int seen = 0;
    out_ready = 1'b0; flush = 1'b0;
    fill_random(); mode = 2'd1; in_valid = 1'b1;
    step();
    fill_random();
    step();
    in_valid = 1'b0;
    step();
`ifdef DATAFLOW_PERF_EN
    checks++;
    if (stall_count !== 32'd1) begin errors++; $display("FAIL flush_pre_stall: stall=%0d want 1", stall_count); end
`endif
    fill_random(); in_valid = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_cycle: in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
    end
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
`ifdef DATAFLOW_PERF_EN
    checks++;
    if (xfer_count !== 32'd0 || stall_count !== 32'd0) begin
      errors++; $display("FAIL flush_counters: xfer=%0d stall=%0d want 0/0", xfer_count, stall_count);
    end
`endif
    for (int c = 0; c < 3; c++) begin
      step(); #1;
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL flush_leak: out_valid high %0d cycles after flush, want 0", seen); end
  endtask

  task automatic test_reset_mid();
    tile_t zero_t;
    int d;
    for (int i = 0; i < LANE; i++)
      for (int k = 0; k < TILE; k++)
        zero_t[i][k] = '0;
    out_ready = 1'b0; flush = 1'b0;
    fill_random(); mode = 2'd1; in_valid = 1'b1;
    step();
    fill_random();
    step();
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_pre_block: in_ready=%b want 0", in_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_async: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    fill_random(); mode = 2'd3; src_lane = SRC_W'($urandom()); out_ready = 1'b1;
    #1 rst_n = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_c1: out_valid=%b want 0", out_valid); end
    step(); #1;
    d = tile_diff(out_tile, zero_t);
    checks++;
    if (out_valid !== 1'b1 || d != 0) begin
      errors++; $display("FAIL mid_zero: out_valid=%b nonzero_words=%0d want 1/0", out_valid, d);
    end
    step(); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_drain: out_valid=%b want 0", out_valid); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_pass();
    test_bcast();
    test_rot();
    test_back_to_back();
    test_random_stream();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
